// File: rtl/series_operand_feeder.sv
// rtl/series_operand_feeder.sv - operand FIFO and launch sequencer for the series-evaluation engine
//
// Buffers operand words and launches one engine evaluation per word: x_out is
// loaded at the pop, start is held high for START_LEN cycles, then the block
// waits for the engine to leave idle and return before the next launch.
// Optional build macro: SERIES_FEEDER_TIMEOUT_EN (bounded WAIT_DONE, sticky err).
//
// Ports:
//   clk        clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   in_valid   operand offered
//   in_ready   FIFO not full
//   in_data    operand value
//   eng_idle   engine controller is idle
//   start      start level to the engine
//   x_out      operand currently launched
//   fifo_level number of buffered entries
//   job_cnt    completed jobs, wraps at 256
//   err        sticky timeout flag (tied 0 without the timeout build)
module series_operand_feeder #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 4,
  parameter int START_LEN = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       eng_idle,
  output logic                       start,
  output logic [DATA_W-1:0]          x_out,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [7:0]                 job_cnt,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(START_LEN + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic [CW-1:0]     cnt;
  logic              busy_seen;
  logic              push, pop, done;

  assign in_ready   = (level != LW'(DEPTH));
  assign fifo_level = level;
  assign push       = in_valid && in_ready;

`ifdef SERIES_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
  logic          tout;

  // Counter is zero on every WAIT_DONE entry because it is held clear elsewhere.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state != WAIT_DONE) to_cnt <= '0;
      else                    to_cnt <= to_cnt + 1'b1;
      if (tout) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    pop      = 1'b0;
    done     = 1'b0;
`ifdef SERIES_FEEDER_TIMEOUT_EN
    tout     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (level != '0 && eng_idle) begin
          pop      = 1'b1;
          state_nx = LAUNCH;
        end
      end
      LAUNCH: begin
        start = 1'b1;
        if (cnt == '0) state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A stale idle level from before the launch must not count as completion.
        if (busy_seen && eng_idle) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
`ifdef SERIES_FEEDER_TIMEOUT_EN
        else if (to_cnt == TW'(TIMEOUT - 1)) begin
          tout     = 1'b1;
          state_nx = IDLE;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      x_out     <= '0;
      job_cnt   <= '0;
      busy_seen <= 1'b0;
      cnt       <= '0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        x_out     <= mem[rd_ptr];
        busy_seen <= 1'b0;
        cnt       <= CW'(START_LEN - 1);
      end else if ((state == LAUNCH || state == WAIT_DONE) && !eng_idle) begin
        busy_seen <= 1'b1;
      end
      if (state == LAUNCH && cnt != '0) cnt <= cnt - 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
      if (done) job_cnt <= job_cnt + 1'b1;
    end
  end

endmodule
